wb_commit: RTL
==============

WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width.
REQ-002 SHALL have parameter NREG, default 32, architectural register count.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port w_valid  input  1  W-stage bundle holds a real instruction (0 = bubble).
REQ-006 SHALL have port w_stall  input  1  W-stage register is holding the same bundle this cycle.
REQ-007 SHALL have ports w_instr  input  32, w_pc  input  XLEN, w_control  input  24  W-stage instruction, PC and control word.
REQ-008 SHALL have ports w_alu  input  XLEN, w_mem  input  XLEN, w_ext  input  XLEN  writeback candidates.
REQ-009 SHALL have port w_skip  input  1  instruction is to be skipped by the reference model.
REQ-010 SHALL have ports rs1_addr, rs2_addr  input  5  and rs1_data, rs2_data  output  XLEN  decode-stage read ports.
REQ-011 SHALL have ports commit_valid 1, commit_pc XLEN, commit_instr 32, commit_wen 1, commit_wdest 5, commit_wdata XLEN, commit_skip 1  output  registered commit record.
REQ-012 SHALL have port instret  output  64  retired-instruction count.

Function
REQ-013 SHALL take control fields from the package: CTL_REGWRITE = bit 0; CTL_WBSEL = bits 2:1 (00 ALU, 01 MEM, 10 PC+4, 11 EXT); rd = w_instr[11:7].
REQ-014 SHALL compute wdata combinationally by CTL_WBSEL; PC+4 wraps modulo 2^XLEN.
REQ-015 SHALL hold an internal done flag; a bundle fires when w_valid=1 and done=0.
REQ-016 SHALL, on a firing cycle, set done=1 if w_stall=1, else keep done=0; on any cycle with w_stall=0 and no fire, clear done to 0 (a new bundle arrives next edge).
REQ-017 SHALL write wdata into register rd at the edge ending a firing cycle only when CTL_REGWRITE=1 and rd!=0.
REQ-018 SHALL keep x0 reading zero at all times; writes to x0 are dropped.
REQ-019 SHALL forward: when a read address equals a same-cycle firing write's rd (nonzero, CTL_REGWRITE=1), rsN_data SHALL equal wdata; otherwise the stored value.
REQ-020 SHALL have a one-cycle commit latency: commit_* registered from the firing cycle's values; commit_valid=1 for exactly one cycle per instruction.
REQ-021 SHALL set commit_wen=CTL_REGWRITE && rd!=0; commit_wdest=rd; commit_wdata=wdata when commit_wen=1, else 0.
REQ-022 SHALL increment instret by 1 per fire; wraps at 2^64.
REQ-023 SHALL drive commit_valid=0 on non-firing cycles; other commit_* hold their last value.
REQ-024 SHALL ignore w_* entirely when w_valid=0 (no write, no commit, no count).

Reset
REQ-025 SHALL clear on reset: all registers 0, done 0, instret 0, all commit_* 0.
REQ-026 SHALL give reset priority over a simultaneous fire; the fire is discarded.
REQ-027 SHALL drive rs1_data/rs2_data from cleared contents in the cycle after reset.

Configuration
REQ-028 SHALL use macro WB_COMMIT_TRACE_EN: defined -> commit_* and instret behave per REQ-020..023.
REQ-029 SHALL, with WB_COMMIT_TRACE_EN undefined, tie commit_* and instret to 0 and synthesize no trace/counter flops; register file, forwarding and done flag are unchanged.

Structure
REQ-030 SHALL place CTL_REGWRITE, CTL_WBSEL bit positions, the WB_ALU/WB_MEM/WB_PC4/WB_EXT encodings and the commit-record struct type in the shared common package.
REQ-031 SHALL contain one sub-module, regfile (NREG x XLEN, 2 async read, 1 sync write, x0 hardwired); forwarding and commit logic stay in wb_commit.

Verification
REQ-032 SHALL check: w_valid=1, control wbsel=ALU, regwrite=1, rd=5, w_alu=0x1234 -> next cycle commit_valid=1, commit_wdest=5, commit_wdata=0x1234; rs1_addr=5 reads 0x1234.
REQ-033 SHALL check: same bundle held with w_stall=1 for 3 cycles -> exactly one commit_valid pulse, instret +1, x5 written once.
REQ-034 SHALL check: rd=0, regwrite=1, w_alu=0xFFFF -> commit_wen=0, commit_wdata=0, x0 reads 0, instret +1.
REQ-035 SHALL check: wbsel=PC+4, w_pc=0xFFFF_FFFF_FFFF_FFFC, rd=1 -> x1=0; rs2_addr=1 same cycle reads 0 via forwarding.
REQ-036 SHALL check: reset asserted during a firing cycle -> no commit, instret=0, x-file all 0 next cycle.
REQ-037 SHALL check: back-to-back bundles rd=3 (w_mem=0xA) then rd=3 (w_ext=0xB), no stall -> two commits, x3=0xB, instret +2.

Source files
------------

// File: rtl/wb_commit_pkg.sv
// Shared definitions for the writeback/commit stage: control-word fields,
// writeback-select encodings and the registered commit record.
package wb_commit_pkg;

    localparam int CTL_REGWRITE = 0;
    localparam int CTL_WBSEL_LO = 1;
    localparam int CTL_WBSEL_HI = 2;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_EXT = 2'b11;

    // Sized for the widest supported XLEN (64); narrower builds zero-extend.
    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        wen;
        logic [4:0]  wdest;
        logic [63:0] wdata;
        logic        skip;
    } commit_rec_t;

endpackage

// File: rtl/wb_commit_regfile.sv
// Architectural register file: NREG x XLEN, two async reads, one sync write,
// x0 hardwired to zero; contents cleared by the synchronous reset.
module regfile
    import wb_commit_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs_r [NREG];

    // Storage update: clear on reset, otherwise single write port (x0 never stored).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (we && (wa != 5'd0) && (32'(wa) < NREG)) begin
            regs_r[wa] <= wd;
        end else begin
            regs_r <= regs_r;
        end
    end

    // Asynchronous read ports with x0 and out-of-range addresses reading zero.
    always_comb begin
        rd1 = {XLEN{1'b0}};
        rd2 = {XLEN{1'b0}};
        if ((ra1 != 5'd0) && (32'(ra1) < NREG)) begin
            rd1 = regs_r[ra1];
        end else begin
            rd1 = {XLEN{1'b0}};
        end
        if ((ra2 != 5'd0) && (32'(ra2) < NREG)) begin
            rd2 = regs_r[ra2];
        end else begin
            rd2 = {XLEN{1'b0}};
        end
    end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: retires each W-stage bundle once, writes the register
// file with forwarding to decode, and (with WB_COMMIT_TRACE_EN) emits a commit record.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            w_valid,
    input  logic            w_stall,
    input  logic [31:0]     w_instr,
    input  logic [XLEN-1:0] w_pc,
    input  logic [23:0]     w_control,
    input  logic [XLEN-1:0] w_alu,
    input  logic [XLEN-1:0] w_mem,
    input  logic [XLEN-1:0] w_ext,
    input  logic            w_skip,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [31:0]     commit_instr,
    output logic            commit_wen,
    output logic [4:0]      commit_wdest,
    output logic [XLEN-1:0] commit_wdata,
    output logic            commit_skip,
    output logic [63:0]     instret
);

    logic            done_r;
    logic            fire_s;
    logic            regwrite_s;
    logic [1:0]      wbsel_s;
    logic [4:0]      rd_s;
    logic            wen_s;
    logic [XLEN-1:0] wdata_s;
    logic [XLEN-1:0] rf_rd1_s;
    logic [XLEN-1:0] rf_rd2_s;
    logic            unused_ctl_s;

    assign regwrite_s   = w_control[CTL_REGWRITE];
    assign wbsel_s      = w_control[CTL_WBSEL_HI:CTL_WBSEL_LO];
    assign rd_s         = w_instr[11:7];
    assign fire_s       = w_valid && !done_r;
    assign wen_s        = fire_s && regwrite_s && (rd_s != 5'd0);
    assign unused_ctl_s = ^w_control[23:3];

    // Writeback value selection; PC+4 wraps naturally at XLEN bits.
    always_comb begin
        wdata_s = w_alu;
        case (wbsel_s)
            WB_ALU:  wdata_s = w_alu;
            WB_MEM:  wdata_s = w_mem;
            WB_PC4:  wdata_s = w_pc + XLEN'(3'd4);
            WB_EXT:  wdata_s = w_ext;
            default: wdata_s = w_alu;
        endcase
    end

    // A stalled bundle is retired once; done marks it until the W register advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_r <= 1'b0;
        end else if (fire_s) begin
            done_r <= w_stall;
        end else if (!w_stall) begin
            done_r <= 1'b0;
        end else begin
            done_r <= done_r;
        end
    end

    regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs1_addr),
        .ra2   (rs2_addr),
        .rd1   (rf_rd1_s),
        .rd2   (rf_rd2_s),
        .we    (wen_s),
        .wa    (rd_s),
        .wd    (wdata_s)
    );

    // Decode read ports see the same-cycle write before it lands in the file.
    always_comb begin
        rs1_data = rf_rd1_s;
        rs2_data = rf_rd2_s;
        if (wen_s && (rs1_addr == rd_s)) begin
            rs1_data = wdata_s;
        end else begin
            rs1_data = rf_rd1_s;
        end
        if (wen_s && (rs2_addr == rd_s)) begin
            rs2_data = wdata_s;
        end else begin
            rs2_data = rf_rd2_s;
        end
    end

`ifdef WB_COMMIT_TRACE_EN
    commit_rec_t rec_r;
    logic [63:0] instret_r;

    // Commit record and retire counter: captured on fire, valid pulses one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_r     <= {$bits(commit_rec_t){1'b0}};
            instret_r <= 64'd0;
        end else if (fire_s) begin
            rec_r.valid <= 1'b1;
            rec_r.pc    <= 64'(w_pc);
            rec_r.instr <= w_instr;
            rec_r.wen   <= wen_s;
            rec_r.wdest <= rd_s;
            rec_r.wdata <= wen_s ? 64'(wdata_s) : 64'd0;
            rec_r.skip  <= w_skip;
            instret_r   <= instret_r + 64'd1;
        end else begin
            rec_r.valid <= 1'b0;
            instret_r   <= instret_r;
        end
    end

    assign commit_valid = rec_r.valid;
    assign commit_pc    = rec_r.pc[XLEN-1:0];
    assign commit_instr = rec_r.instr;
    assign commit_wen   = rec_r.wen;
    assign commit_wdest = rec_r.wdest;
    assign commit_wdata = rec_r.wdata[XLEN-1:0];
    assign commit_skip  = rec_r.skip;
    assign instret      = instret_r;
`else
    logic unused_trace_s;
    assign unused_trace_s = ^{w_skip, w_instr[31:12], w_instr[6:0]};

    assign commit_valid = 1'b0;
    assign commit_pc    = {XLEN{1'b0}};
    assign commit_instr = 32'd0;
    assign commit_wen   = 1'b0;
    assign commit_wdest = 5'd0;
    assign commit_wdata = {XLEN{1'b0}};
    assign commit_skip  = 1'b0;
    assign instret      = 64'd0;
`endif

endmodule
